// File: rtl/aqed_chk_pkg.sv
// Shared types and default sizing for the A-QED output consistency checker.
package aqed_chk_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_OUT = 2'd2,
    DONE     = 2'd3
  } chk_state_t;

endpackage

// File: rtl/aqed_out_checker_if.sv
// Bundle of the core-facing event/data signals and the checker verdict flags.
//
// Handshake semantics: there is no back-pressure. in_fire marks one accepted
// core input in the current cycle and qualifies orig_mark/dup_mark; acc_out_v
// marks one core output in the current cycle and qualifies acc_out. Any of
// these is only consumed on a rising clk edge with clk_en=1.
interface aqed_out_checker_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              in_fire;
  logic              orig_mark;
  logic              dup_mark;
  logic [CNT_W-1:0]  out_skip;
  logic [DATA_W-1:0] acc_out;
  logic              acc_out_v;
  logic              qed_done;
  logic              qed_check;
  logic              mark_err;
  logic              qed_timeout;

  modport master (
    output in_fire, orig_mark, dup_mark, out_skip, acc_out, acc_out_v,
    input  qed_done, qed_check, mark_err, qed_timeout
  );

  modport slave (
    input  in_fire, orig_mark, dup_mark, out_skip, acc_out, acc_out_v,
    output qed_done, qed_check, mark_err, qed_timeout
  );
endinterface

// File: rtl/aqed_pos_capture.sv
// Holds one marked input position and captures the output that corresponds
// to it: output number out_cnt belongs to input (out_cnt - out_skip).
module aqed_pos_capture #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_pos,
  input  logic              out_v,
  input  logic [CNT_W-1:0]  out_cnt,
  input  logic [CNT_W-1:0]  out_skip,
  input  logic [DATA_W-1:0] data,
  output logic              hit,
  output logic              got,
  output logic [DATA_W-1:0] val
);

  logic [CNT_W-1:0] pos;
  logic             pos_valid;
  logic [CNT_W:0]   target;

  // One extra bit so pos + out_skip never wraps onto a small out_cnt.
  assign target = {1'b0, pos} + {1'b0, out_skip};

  // Only the first matching output is taken; later ones are ignored.
  assign hit = clk_en & pos_valid & ~got & out_v & ({1'b0, out_cnt} == target);

  // Position latch and value capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pos       <= '0;
      pos_valid <= 1'b0;
      val       <= '0;
      got       <= 1'b0;
    end else if (clk_en) begin
      if (load) begin
        pos       <= load_pos;
        pos_valid <= 1'b1;
      end
      if (hit) begin
        val <= data;
        got <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aqed_out_checker.sv
// A-QED downstream consistency checker: tracks the original and duplicate
// inputs, captures their outputs in stream order and reports done/check.
// Optional feature macro: AQED_TIMEOUT_EN (WAIT_OUT watchdog driving
// qed_timeout; without it qed_timeout is tied low).
module aqed_out_checker
  import aqed_chk_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  aqed_out_checker_if.slave   bus,
  output chk_state_t          state_dbg
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("aqed_out_checker: TIMEOUT must be at least 1");
  end

  chk_state_t        state, state_nxt;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  logic              mark_bad;
  logic              orig_load, dup_load;
  logic              orig_hit, orig_got, dup_hit, dup_got;
  logic [DATA_W-1:0] orig_val, dup_val;
  logic              err_q;

  // Any illegal marking combination; such a cycle never moves the FSM.
  assign mark_bad = (bus.orig_mark & bus.dup_mark)
                  | ((bus.orig_mark | bus.dup_mark) & ~bus.in_fire)
                  | (bus.orig_mark & (state != IDLE))
                  | (bus.dup_mark  & (state != ARMED));

  assign orig_load = clk_en & bus.in_fire & bus.orig_mark & ~mark_bad;
  assign dup_load  = clk_en & bus.in_fire & bus.dup_mark  & ~mark_bad;

  aqed_pos_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_orig (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (orig_load),
    .load_pos (in_cnt),
    .out_v    (bus.acc_out_v),
    .out_cnt  (out_cnt),
    .out_skip (bus.out_skip),
    .data     (bus.acc_out),
    .hit      (orig_hit),
    .got      (orig_got),
    .val      (orig_val)
  );

  aqed_pos_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dup (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (dup_load),
    .load_pos (in_cnt),
    .out_v    (bus.acc_out_v),
    .out_cnt  (out_cnt),
    .out_skip (bus.out_skip),
    .data     (bus.acc_out),
    .hit      (dup_hit),
    .got      (dup_got),
    .val      (dup_val)
  );

  // Next-state: marks advance IDLE/ARMED, captures complete WAIT_OUT.
  always_comb begin
    state_nxt = state;
    if (!mark_bad) begin
      case (state)
        IDLE:     if (bus.in_fire && bus.orig_mark) state_nxt = ARMED;
        ARMED:    if (bus.in_fire && bus.dup_mark)  state_nxt = WAIT_OUT;
        WAIT_OUT: if ((orig_got || orig_hit) && (dup_got || dup_hit))
                    state_nxt = DONE;
        DONE:     state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // State register; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (!reset)      state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  // Saturating input/output counters; positions latch the pre-increment value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (clk_en) begin
      if (bus.in_fire   && (in_cnt  != '1)) in_cnt  <= in_cnt  + 1'b1;
      if (bus.acc_out_v && (out_cnt != '1)) out_cnt <= out_cnt + 1'b1;
    end
  end

  // Sticky illegal-marking flag.
  always_ff @(posedge clk) begin
    if (!reset)                  err_q <= 1'b0;
    else if (clk_en && mark_bad) err_q <= 1'b1;
  end

`ifdef AQED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  // Watchdog: counts cycles spent in WAIT_OUT; flag is sticky, FSM keeps waiting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else if (clk_en) begin
      if (state == ARMED && state_nxt == WAIT_OUT) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_OUT && state_nxt != DONE) begin
        if (tmo_cnt == TW'(TIMEOUT - 1)) tmo_q   <= 1'b1;
        else                             tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign bus.qed_timeout = tmo_q;
`else
  assign bus.qed_timeout = 1'b0;
`endif

  assign bus.qed_done  = (state == DONE);
  assign bus.qed_check = (state == DONE) && (orig_val == dup_val);
  assign bus.mark_err  = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_aqed_out_checker.sv
// Self-checking bench for aqed_out_checker. Each cycle pushes the expected
// {state, done, check, mark_err, timeout} word and compares it after the edge.
module tb_aqed_out_checker;
  import aqed_chk_pkg::*;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;

`ifdef AQED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       clk_en = 1'b0;
  chk_state_t state_dbg;

  always #5 clk = ~clk;

  aqed_out_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  aqed_out_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] fl(chk_state_t s, logic d, logic c, logic e, logic t);
    return {s, d, c, e, t};
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input string tag, input logic rst_n, input logic ce,
                     input logic fire, input logic om, input logic dm,
                     input logic ov, input logic [DATA_W-1:0] d,
                     input logic [5:0] e);
    logic [5:0] x;
    reset         = rst_n;
    clk_en        = ce;
    bus.in_fire   = fire;
    bus.orig_mark = om;
    bus.dup_mark  = dm;
    bus.acc_out_v = ov;
    bus.acc_out   = ov ? d : DATA_W'($urandom_range(0, 65535));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check_eq(tag, {26'd0, state_dbg, bus.qed_done, bus.qed_check,
                   bus.mark_err, bus.qed_timeout}, {26'd0, x});
  endtask

  task automatic do_reset(input string tag, input logic [CNT_W-1:0] skip);
    bus.out_skip = skip;
    cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, fl(IDLE, 0, 0, 0, 0));
  endtask

  // out_skip=0, orig=input 2, dup=input 5, outputs lag inputs by one cycle.
  task automatic run_echo(input string tag, input logic [DATA_W-1:0] last);
    logic [DATA_W-1:0] outs[6];
    chk_state_t        st[7];
    logic              ck;
    outs = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, last};
    st   = '{IDLE, IDLE, ARMED, ARMED, ARMED, WAIT_OUT, DONE};
    ck   = (last == 16'd12);
    do_reset({tag, "_rst"}, '0);
    for (int c = 0; c < 7; c++) begin
      cyc($sformatf("%s_c%0d", tag, c), 1'b1, 1'b1, c < 6, c == 2, c == 5,
          c >= 1, (c >= 1) ? outs[c-1] : '0,
          fl(st[c], c == 6, (c == 6) && ck, 0, 0));
    end
    cyc({tag, "_hold"}, 1'b1, 1'b1, 0, 0, 0, 0, '0, fl(DONE, 1, ck, 0, 0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_fire   = 1'b0;
    bus.orig_mark = 1'b0;
    bus.dup_mark  = 1'b0;
    bus.acc_out_v = 1'b0;
    bus.acc_out   = '0;
    bus.out_skip  = '0;

    do_reset("reset0", '0);
    do_reset("reset1", '0);

    // Matching and mismatching duplicate output.
    run_echo("echo_eq", 16'd12);
    run_echo("echo_ne", 16'd99);

    // Warm-up skip of 3: only outputs 3 and 4 are captured.
    do_reset("skip_rst", 16'd3);
    cyc("skip_c0", 1, 1, 1, 1, 0, 1, 16'd7,  fl(ARMED,    0, 0, 0, 0));
    cyc("skip_c1", 1, 1, 1, 0, 1, 1, 16'd7,  fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("skip_c2", 1, 1, 0, 0, 0, 1, 16'd8,  fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("skip_c3", 1, 1, 0, 0, 0, 1, 16'd20, fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("skip_c4", 1, 1, 0, 0, 0, 1, 16'd20, fl(DONE,     1, 1, 0, 0));
    cyc("skip_c5", 1, 1, 0, 0, 0, 1, 16'd99, fl(DONE,     1, 1, 0, 0));

    // Illegal markings.
    do_reset("err_rst0", '0);
    cyc("err_both",    1, 1, 1, 1, 1, 0, '0, fl(IDLE,  0, 0, 1, 0));
    cyc("err_sticky",  1, 1, 0, 0, 0, 0, '0, fl(IDLE,  0, 0, 1, 0));
    do_reset("err_rst1", '0);
    cyc("err_dupidle", 1, 1, 1, 0, 1, 0, '0, fl(IDLE,  0, 0, 1, 0));
    do_reset("err_rst2", '0);
    cyc("err_nofire",  1, 1, 0, 1, 0, 0, '0, fl(IDLE,  0, 0, 1, 0));
    do_reset("err_rst3", '0);
    cyc("err_orig_ok", 1, 1, 1, 1, 0, 0, '0, fl(ARMED, 0, 0, 0, 0));
    cyc("err_orig2",   1, 1, 1, 1, 0, 0, '0, fl(ARMED, 0, 0, 1, 0));

    // Reset in WAIT_OUT after orig captured, then a fresh pair.
    do_reset("rw_rst", '0);
    cyc("rw_c0", 1, 1, 1, 1, 0, 0, '0,    fl(ARMED,    0, 0, 0, 0));
    cyc("rw_c1", 1, 1, 1, 0, 1, 1, 16'd5, fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("rw_c2", 1, 1, 0, 0, 0, 0, '0,    fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("rw_c3", 0, 1, 0, 0, 0, 0, '0,    fl(IDLE,     0, 0, 0, 0));
    cyc("rw_c4", 1, 1, 1, 1, 0, 0, '0,    fl(ARMED,    0, 0, 0, 0));
    cyc("rw_c5", 1, 1, 1, 0, 1, 1, 16'd6, fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("rw_c6", 1, 1, 0, 0, 0, 1, 16'd6, fl(DONE,     1, 1, 0, 0));

    // clk_en=0 freezes everything; reset still wins over clk_en.
    do_reset("ce_rst", '0);
    cyc("ce_c0", 1, 0, 1, 1, 0, 1, 16'd3,  fl(IDLE,     0, 0, 0, 0));
    cyc("ce_c1", 1, 1, 1, 0, 0, 0, '0,     fl(IDLE,     0, 0, 0, 0));
    cyc("ce_c2", 1, 1, 1, 1, 0, 1, 16'd1,  fl(ARMED,    0, 0, 0, 0));
    cyc("ce_c3", 1, 1, 1, 0, 1, 1, 16'd42, fl(WAIT_OUT, 0, 0, 0, 0));
    cyc("ce_c4", 1, 1, 0, 0, 0, 1, 16'd42, fl(DONE,     1, 1, 0, 0));
    cyc("ce_c5", 1, 0, 0, 0, 0, 1, 16'd9,  fl(DONE,     1, 1, 0, 0));
    cyc("ce_c6", 0, 0, 0, 0, 0, 0, '0,     fl(IDLE,     0, 0, 0, 0));

    // Outputs withheld in WAIT_OUT: watchdog fires after TIMEOUT cycles.
    do_reset("tmo_rst", '0);
    cyc("tmo_c0", 1, 1, 1, 1, 0, 0, '0, fl(ARMED,    0, 0, 0, 0));
    cyc("tmo_c1", 1, 1, 1, 0, 1, 0, '0, fl(WAIT_OUT, 0, 0, 0, 0));
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      cyc($sformatf("tmo_w%0d", k), 1, 1, 0, 0, 0, 0, '0,
          fl(WAIT_OUT, 0, 0, 0, TMO_EN && (k >= TIMEOUT)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
